// File: rtl/gf2_datapath_core.sv
// GF(2) polynomial datapath: one-cycle XOR / square / byte-mask and a
// digit-serial (DIG bits per cycle, MSB-first) unreduced carry-less multiplier.
module gf2_datapath_core #(
   parameter int          W    = 128,
   parameter int          DIG  = 4,
   parameter logic [2:0]  SQR  = 3'b001,
   parameter logic [2:0]  XOR  = 3'b010,
   parameter logic [2:0]  MUL  = 3'b011,
   parameter logic [2:0]  MASK = 3'b100
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [2:0]   select_line,
   input  logic [W-1:0] A,
   input  logic [W-1:0] B,
   output logic         busy,
   output logic         done,
   output logic         err,
   output logic [W-1:0] C_Out,
   output logic [W-1:0] D_Out
);

   localparam int N  = W / DIG;
   localparam int CW = (N > 1) ? $clog2(N) : 1;

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RUN  = 2'd1;
   localparam logic [1:0] DONE = 2'd2;

   logic [1:0]     state;
   logic [CW-1:0]  cnt;
   logic [W-1:0]   a_reg;
   logic [W-1:0]   b_reg;
   logic [2*W-1:0] acc;
   logic [2*W-1:0] acc_next;
   logic [2*W-1:0] op_res;
   logic           op_err;
   logic [DIG-1:0] digit;
   logic           last;

   assign busy  = (state == RUN);
   assign digit = b_reg[W-1 -: DIG];
   assign last  = (cnt == CW'(N - 1));

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      op_res = '0;
      op_err = 1'b0;
      case (select_line)
         SQR:  for (int i = 0; i < W; i++) op_res[2*i] = B[i];
         XOR:  op_res[W-1:0] = A ^ B;
         MASK: for (int k = 0; k < W/8; k++) op_res[8*k +: 8] = B[k] ? A[8*k +: 8] : 8'h00;
         MUL:  ;
         default: op_err = 1'b1;
      endcase
   end

   // Horner step: shift the running product by one digit, fold in A * digit.
   always_comb begin
      acc_next = acc << DIG;
      for (int j = 0; j < DIG; j++)
         if (digit[j]) acc_next = acc_next ^ ({{W{1'b0}}, a_reg} << j);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         done  <= 1'b0;
         err   <= 1'b0;
         C_Out <= '0;
         D_Out <= '0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            RUN: begin
               cnt <= cnt + 1'b1;
               if (last) begin
                  state          <= DONE;
                  done           <= 1'b1;
                  {C_Out, D_Out} <= acc_next;
               end
            end
            default: begin
               if (start) begin
                  if (select_line == MUL) begin
                     state <= RUN;
                     cnt   <= '0;
                  end else begin
                     state          <= DONE;
                     done           <= 1'b1;
                     err            <= op_err;
                     {C_Out, D_Out} <= op_res;
                  end
               end else begin
                  state <= IDLE;
               end
            end
         endcase
      end
   end

   // NOTE: operand/accumulator registers carry no reset; they are always loaded before use.
   always_ff @(posedge clk) begin
      if (state == RUN) begin
         acc   <= acc_next;
         b_reg <= b_reg << DIG;
      end else if (start) begin
         a_reg <= A;
         b_reg <= B;
         acc   <= '0;
      end
   end

endmodule
